// File: rtl/xreg_bus_slave.sv
// xreg_bus_slave: APB3 responder for an xregister bank.
//
// Every transfer takes three bus cycles (one wait state):
//   T   IDLE  setup phase seen; decode paddr and latch the request
//   T+1 STRB  one-cycle sw_wr/sw_rd strobe; capture the selected register
//   T+2 DONE  pready=1 with prdata/pslverr
//
// Handshake: the bus side follows APB3. A transfer starts only on a setup
// phase (psel=1, penable=0) seen in IDLE. pready is high for exactly one
// cycle (DONE), and prdata/pslverr are valid only while pready=1. The
// sw_wr/sw_rd strobes toward the bank are single-cycle and carry no
// back-pressure.
//
// Optional feature: define XREG_PSLVERR_EN to return pslverr=1 for unmapped
// or misaligned transfers. Without it pslverr stays 0.
//
// Ports:
//   clk, rst_n       bank clock, asynchronous active-low reset
//   psel, penable    APB select / access phase
//   pwrite           1=write, 0=read
//   paddr, pwdata    byte address, write data
//   pready           transfer complete
//   prdata           read data (0 on writes and unmapped reads)
//   pslverr          error response
//   sw_wr, sw_rd     one-hot per-register write/read strobes, 1 cycle
//   sw_wr_data       write data to the fields, held until the next mapped write
//   reg_rd_data      packed register values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module xreg_bus_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_CNT    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          pready,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pslverr,
  output logic [REG_CNT-1:0]            sw_wr,
  output logic [REG_CNT-1:0]            sw_rd,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [DATA_WIDTH*REG_CNT-1:0] reg_rd_data
);

  localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Latched request
  logic             is_wr_q, is_wr_n;
  logic             hit_q, hit_n;
  logic [IDX_W-1:0] idx_q, idx_n;

  // Next values of the registered outputs
  logic [REG_CNT-1:0]    sw_wr_n, sw_rd_n;
  logic [DATA_WIDTH-1:0] sw_wr_data_n, prdata_n;
  logic                  pready_n, pslverr_n;

  // Address decode. The subtraction wraps at ADDR_WIDTH bits, so
  // addresses below BASE_ADDR are rejected explicitly.
  logic [ADDR_WIDTH-1:0] addr_off, addr_word;
  logic [IDX_W-1:0]      addr_idx;
  logic                  addr_hit;

  always_comb begin
    addr_off  = paddr - BASE_ADDR;
    addr_word = addr_off >> SHIFT;
    addr_idx  = IDX_W'(addr_word);
    addr_hit  = (paddr >= BASE_ADDR) &&
                ((addr_off & ALIGN_MASK) == '0) &&
                (32'(addr_word) < 32'(REG_CNT));
  end

  // Register read mux
  logic [DATA_WIDTH-1:0] rd_arr [REG_CNT];
  for (genvar i = 0; i < REG_CNT; i++) begin : g_rd
    assign rd_arr[i] = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_n      = state;
    is_wr_n      = is_wr_q;
    hit_n        = hit_q;
    idx_n        = idx_q;
    sw_wr_n      = '0;
    sw_rd_n      = '0;
    sw_wr_data_n = sw_wr_data;
    pready_n     = 1'b0;
    prdata_n     = '0;
    pslverr_n    = 1'b0;
    case (state)
      IDLE: begin
        // penable=1 in IDLE is a protocol error and is ignored
        if (psel && !penable) begin
          state_n = STRB;
          is_wr_n = pwrite;
          hit_n   = addr_hit;
          idx_n   = addr_idx;
          if (addr_hit) begin
            if (pwrite) begin
              sw_wr_n      = REG_CNT'(1) << addr_idx;
              sw_wr_data_n = pwdata;
            end else begin
              sw_rd_n = REG_CNT'(1) << addr_idx;
            end
          end
        end
      end
      STRB: begin
        // Capture happens on the strobe edge, so read-side-effect fields
        // still present their old value here.
        if (psel) begin
          state_n  = DONE;
          pready_n = 1'b1;
          if (hit_q && !is_wr_q) prdata_n = rd_arr[idx_q];
`ifdef XREG_PSLVERR_EN
          pslverr_n = !hit_q;
`endif
        end else begin
          // Transfer abandoned: strobe already issued stands, no response
          state_n = IDLE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr_q    <= 1'b0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      sw_wr      <= '0;
      sw_rd      <= '0;
      sw_wr_data <= '0;
      pready     <= 1'b0;
      prdata     <= '0;
      pslverr    <= 1'b0;
    end else begin
      is_wr_q    <= is_wr_n;
      hit_q      <= hit_n;
      idx_q      <= idx_n;
      sw_wr      <= sw_wr_n;
      sw_rd      <= sw_rd_n;
      sw_wr_data <= sw_wr_data_n;
      pready     <= pready_n;
      prdata     <= prdata_n;
      pslverr    <= pslverr_n;
    end
  end

endmodule

// File: tb/tb_xreg_bus_slave.sv
// Testbench for xreg_bus_slave (default parameters: 8-bit address,
// 32-bit data, 16 registers, base 0). A small register-bank model answers
// the strobes; register 3 can be switched to read-clear behaviour.
module tb_xreg_bus_slave;

`ifdef XREG_PSLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [15:0] sw_wr, sw_rd;
  logic [31:0] sw_wr_data;
  logic [511:0] reg_rd_data;

  xreg_bus_slave dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(sw_wr_data),
    .reg_rd_data(reg_rd_data)
  );

  // Register bank model
  logic [31:0] regs [16];
  logic        rc_en, pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    for (int i = 0; i < 16; i++) begin
      if (sw_wr[i]) regs[i] <= sw_wr_data;
      else if (sw_rd[i] && rc_en && i == 3) regs[i] <= 32'h0;
    end
  end

  always_comb begin
    reg_rd_data = '0;
    for (int i = 0; i < 16; i++) reg_rd_data[i*32 +: 32] = regs[i];
  end

  // Strobe / response monitor
  int cyc = 0, strb_cnt = 0, rdy_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|sw_wr) last_wr_cyc <= cyc;
    if (|sw_rd) last_rd_cyc <= cyc;
    if ((|sw_wr) || (|sw_rd)) strb_cnt <= strb_cnt + 1;
    if (pready) rdy_cnt <= rdy_cnt + 1;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int tests_run = 0, tests_failed = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  // Driver tasks (called at posedge+1, return at posedge+1)
  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [15:0] wr1, output logic [15:0] rd1,
                          output logic rdy1, output logic [15:0] strb2,
                          output logic rdy2, output logic [31:0] rdata,
                          output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); wr1 = sw_wr; rd1 = sw_rd; rdy1 = pready;
    @(posedge clk); #1;
    @(negedge clk); strb2 = sw_wr | sw_rd; rdy2 = pready; rdata = prdata; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  logic [15:0] wr1, rd1, strb2;
  logic        rdy1, rdy2, err;
  logic [31:0] rdata;

  task automatic test_reset();
    tests_run++;
    if ({pready, pslverr, prdata, sw_wr, sw_rd, sw_wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h wr=%h rs=%h wd=%h, want all 0",
               pready, pslverr, prdata, sw_wr, sw_rd, sw_wr_data);
    end
  endtask

  task automatic test_write();
    exp_q.push_back(32'h0);
    apb_xfer(1'b1, 8'h08, 32'hA5A5_0001, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (wr1 !== 16'h0004 || rd1 !== 16'h0) begin
      tests_failed++; $display("FAIL write_strobe: got wr=%h rd=%h, want wr=0004 rd=0000", wr1, rd1);
    end
    tests_run++;
    if (rdy1 !== 1'b0 || rdy2 !== 1'b1 || strb2 !== 16'h0) begin
      tests_failed++; $display("FAIL write_timing: got rdy1=%b rdy2=%b strb2=%h, want 0 1 0000", rdy1, rdy2, strb2);
    end
    tests_run++;
    if (rdata !== exp || err !== 1'b0) begin
      tests_failed++; $display("FAIL write_resp: got prdata=%h err=%b, want %h 0", rdata, err, exp);
    end
    tests_run++;
    if (sw_wr_data !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL write_data: got %h want a5a50001", sw_wr_data);
    end
  endtask

  task automatic test_read_rc();
    rc_en = 1'b1;
    preload(4'd3, 32'h0000_1234);
    exp_q.push_back(32'h0000_1234);
    apb_xfer(1'b0, 8'h0C, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd1 !== 16'h0008 || wr1 !== 16'h0) begin
      tests_failed++; $display("FAIL read_strobe: got rd=%h wr=%h, want rd=0008 wr=0000", rd1, wr1);
    end
    tests_run++;
    if (rdata !== exp || rdy2 !== 1'b1 || err !== 1'b0) begin
      tests_failed++; $display("FAIL read_rc_data: got prdata=%h rdy=%b err=%b, want %h 1 0", rdata, rdy2, err, exp);
    end
    // The read-clear has now taken effect in the bank
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 8'h0C, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rdata !== exp) begin
      tests_failed++; $display("FAIL read_after_clear: got %h want %h", rdata, exp);
    end
    rc_en = 1'b0;
  endtask

  task automatic test_unmapped();
    preload(4'd0, 32'h0000_CAFE);
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 8'd64, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if ((wr1 | rd1) !== 16'h0 || rdata !== exp || err !== ERR_EXP || rdy2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmapped_read: got strb=%h prdata=%h err=%b rdy=%b, want 0000 %h %b 1",
               wr1 | rd1, rdata, err, rdy2, exp, ERR_EXP);
    end
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 8'd2, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if ((wr1 | rd1) !== 16'h0 || rdata !== exp || err !== ERR_EXP || rdy2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_read: got strb=%h prdata=%h err=%b rdy=%b, want 0000 %h %b 1",
               wr1 | rd1, rdata, err, rdy2, exp, ERR_EXP);
    end
    apb_xfer(1'b1, 8'd64, 32'hDEAD_BEEF, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    tests_run++;
    if ((wr1 | rd1) !== 16'h0 || sw_wr_data !== 32'hA5A5_0001 || err !== ERR_EXP) begin
      tests_failed++;
      $display("FAIL unmapped_write: got strb=%h wdata=%h err=%b, want 0000 a5a50001 %b",
               wr1 | rd1, sw_wr_data, err, ERR_EXP);
    end
  endtask

  task automatic test_idle_penable();
    int s0, r0;
    s0 = strb_cnt; r0 = rdy_cnt;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h0;
    repeat (2) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (strb_cnt - s0 !== 0 || rdy_cnt - r0 !== 0) begin
      tests_failed++; $display("FAIL idle_penable: got strobes=%0d readys=%0d, want 0 0", strb_cnt - s0, rdy_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    apb_xfer(1'b1, 8'h14, 32'h5555_AAAA, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp_q.push_back(32'h5555_AAAA);
    apb_xfer(1'b0, 8'h14, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rdata !== exp || rd1 !== 16'h0020) begin
      tests_failed++; $display("FAIL b2b_read: got prdata=%h rd=%h, want %h 0020", rdata, rd1, exp);
    end
    tests_run++;
    if (last_rd_cyc - last_wr_cyc !== 3) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d cycles want 3", last_rd_cyc - last_wr_cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w_seen;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h1111_2222;
    @(posedge clk); #1 penable = 1'b1;
    w_seen = sw_wr;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (w_seen !== 16'h0002 ||
        {pready, pslverr, prdata, sw_wr, sw_rd, sw_wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: strobe before=%h (want 0002), after rdy=%b err=%b rd=%h wr=%h rs=%h wd=%h (want 0)",
               w_seen, pready, pslverr, prdata, sw_wr, sw_rd, sw_wr_data);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b1, 8'h10, 32'h0000_0044, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp_q.push_back(32'h0000_0044);
    apb_xfer(1'b0, 8'h10, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rdata !== exp || rdy2 !== 1'b1) begin
      tests_failed++; $display("FAIL after_reset_xfer: got prdata=%h rdy=%b, want %h 1", rdata, rdy2, exp);
    end
  endtask

  task automatic test_psel_drop();
    int s0, r0;
    logic [15:0] rs;
    preload(4'd2, 32'h0BAD_F00D);
    s0 = strb_cnt; r0 = rdy_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge clk); #1 psel = 1'b0;
    @(negedge clk); rs = sw_rd;
    @(posedge clk); #1;
    tests_run++;
    if (rs !== 16'h0004 || strb_cnt - s0 !== 1) begin
      tests_failed++; $display("FAIL psel_drop_strobe: got rd=%h count=%0d, want 0004 1", rs, strb_cnt - s0);
    end
    // New setup immediately: only accepted if the FSM is back in IDLE
    exp_q.push_back(32'h0BAD_F00D);
    apb_xfer(1'b0, 8'h08, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd1 !== 16'h0004 || rdata !== exp || rdy2 !== 1'b1) begin
      tests_failed++; $display("FAIL psel_drop_next: got rd=%h prdata=%h rdy=%b, want 0004 %h 1", rd1, rdata, rdy2, exp);
    end
    tests_run++;
    if (rdy_cnt - r0 !== 1) begin
      tests_failed++; $display("FAIL psel_drop_ready: got %0d pready cycles want 1", rdy_cnt - r0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  idx;
    logic [31:0] d;
    for (int n = 0; n < 8; n++) begin
      idx = 4'($urandom_range(0, 15));
      d   = $urandom;
      apb_xfer(1'b1, {2'b00, idx, 2'b00}, d, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
      tests_run++;
      if (wr1 !== (16'h1 << idx)) begin
        tests_failed++; $display("FAIL rand_wr_strobe: idx=%0d got %h want %h", idx, wr1, 16'h1 << idx);
      end
      exp_q.push_back(d);
      apb_xfer(1'b0, {2'b00, idx, 2'b00}, 32'h0, wr1, rd1, rdy1, strb2, rdy2, rdata, err);
      exp = exp_q.pop_front();
      tests_run++;
      if (rdata !== exp) begin
        tests_failed++; $display("FAIL rand_read: idx=%0d got %h want %h", idx, rdata, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rc_en = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_write();
    test_read_rc();
    test_unmapped();
    test_idle_penable();
    test_back_to_back();
    test_reset_mid();
    test_psel_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
